// File: rtl/mandel_pkg.sv
// Shared types and constants for the Mandelbrot pixel scanner.
package mandel_pkg;

  localparam int unsigned COORD_W_DEF = 32;
  localparam int unsigned FRAC_BITS   = COORD_W_DEF - 4;

  typedef logic signed [COORD_W_DEF-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mandel_pixel_scanner.sv
// Walks a frame row by row, emitting LANES pixel coordinates per beat in Q4.(COORD_W-4).
// Coordinates are stepped incrementally by delta; lane offsets k*delta are built once at start.
module mandel_pixel_scanner
  import mandel_pkg::*;
#(
  parameter int unsigned LANES   = 1,
  parameter int unsigned XY_W    = 10,
  parameter int unsigned COORD_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [XY_W-1:0]          x_size,
  input  logic [XY_W-1:0]          y_size,
  input  logic [COORD_W-1:0]       re_min,
  input  logic [COORD_W-1:0]       im_max,
  input  logic [COORD_W-1:0]       delta,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [XY_W-1:0]          out_x,
  output logic [XY_W-1:0]          out_y,
  output logic [LANES*COORD_W-1:0] out_re,
  output logic [COORD_W-1:0]       out_im,
  output logic [LANES-1:0]         out_mask,
  output logic                     out_eol,
  output logic                     out_eof,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned XE    = XY_W + 3;
  localparam int unsigned LOG_L = (LANES == 4) ? 2 : ((LANES == 2) ? 1 : 0);

  state_t                   state, state_nxt;
  logic [XY_W-1:0]          xs_q, ys_q, xs_nxt, ys_nxt;
  logic [COORD_W-1:0]       re_min_q, delta_q, re_min_nxt, delta_nxt;
  logic [LANES*COORD_W-1:0] off_q, off_nxt, off_new;
  logic [XY_W-1:0]          x_nxt, y_nxt;
  logic [LANES*COORD_W-1:0] re_nxt;
  logic [COORD_W-1:0]       im_nxt;
  logic [COORD_W-1:0]       step;
  logic [LANES-1:0]         mask_nxt;
  logic                     eol_nxt, eof_nxt, flags_upd;

  // Lane offsets k*delta from shifts and adds (k <= 3)
  always_comb begin
    off_new = '0;
    for (int k = 0; k < LANES; k++) begin
      case (k)
        1:       off_new[k*COORD_W +: COORD_W] = delta;
        2:       off_new[k*COORD_W +: COORD_W] = delta << 1;
        3:       off_new[k*COORD_W +: COORD_W] = delta + (delta << 1);
        default: off_new[k*COORD_W +: COORD_W] = '0;
      endcase
    end
  end

  assign step = delta_q << LOG_L;

  // Next state and next datapath values
  always_comb begin
    state_nxt  = state;
    xs_nxt     = xs_q;
    ys_nxt     = ys_q;
    re_min_nxt = re_min_q;
    delta_nxt  = delta_q;
    off_nxt    = off_q;
    x_nxt      = out_x;
    y_nxt      = out_y;
    re_nxt     = out_re;
    im_nxt     = out_im;
    flags_upd  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          xs_nxt     = x_size;
          ys_nxt     = y_size;
          re_min_nxt = re_min;
          delta_nxt  = delta;
          off_nxt    = off_new;
          if (x_size == '0 || y_size == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SCAN;
            x_nxt     = '0;
            y_nxt     = '0;
            im_nxt    = im_max;
            flags_upd = 1'b1;
            for (int k = 0; k < LANES; k++)
              re_nxt[k*COORD_W +: COORD_W] = re_min + off_new[k*COORD_W +: COORD_W];
          end
        end
      end
      SCAN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (out_ready) begin
          if (out_eof) begin
            state_nxt = DONE;
          end else if (out_eol) begin
            x_nxt     = '0;
            y_nxt     = out_y + XY_W'(1);
            im_nxt    = out_im - delta_q;
            flags_upd = 1'b1;
            for (int k = 0; k < LANES; k++)
              re_nxt[k*COORD_W +: COORD_W] = re_min_q + off_q[k*COORD_W +: COORD_W];
          end else begin
            x_nxt     = out_x + XY_W'(LANES);
            flags_upd = 1'b1;
            for (int k = 0; k < LANES; k++)
              re_nxt[k*COORD_W +: COORD_W] = out_re[k*COORD_W +: COORD_W] + step;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat flags for the position about to be presented
  always_comb begin
    mask_nxt = out_mask;
    eol_nxt  = out_eol;
    eof_nxt  = out_eof;
    if (flags_upd) begin
      for (int k = 0; k < LANES; k++)
        mask_nxt[k] = (XE'(x_nxt) + XE'(k)) < XE'(xs_nxt);
      eol_nxt = (XE'(x_nxt) + XE'(LANES)) >= XE'(xs_nxt);
      eof_nxt = eol_nxt && (y_nxt == ys_nxt - XY_W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xs_q      <= '0;
      ys_q      <= '0;
      re_min_q  <= '0;
      delta_q   <= '0;
      off_q     <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_re    <= '0;
      out_im    <= '0;
      out_mask  <= '0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      xs_q      <= xs_nxt;
      ys_q      <= ys_nxt;
      re_min_q  <= re_min_nxt;
      delta_q   <= delta_nxt;
      off_q     <= off_nxt;
      out_x     <= x_nxt;
      out_y     <= y_nxt;
      out_re    <= re_nxt;
      out_im    <= im_nxt;
      out_mask  <= mask_nxt;
      out_eol   <= eol_nxt;
      out_eof   <= eof_nxt;
      out_valid <= (state_nxt == SCAN);
      busy      <= (state_nxt == SCAN);
      done      <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_mandel_pixel_scanner.sv
// Self-checking bench: expected beat table fed through a scoreboard, plus hand-written corner cases.
module tb_mandel_pixel_scanner;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [31:0] re;
    logic [31:0] im;
    logic        eol;
    logic        eof;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, ready = 1'b1;
  logic [9:0]  x_size = 10'd3, y_size = 10'd2;
  logic [31:0] re_min = 32'hE000_0000, im_max = 32'h1000_0000, delta = 32'h0800_0000;

  logic        out_valid, out_eol, out_eof, busy, done;
  logic [9:0]  out_x, out_y;
  logic [31:0] out_re, out_im;
  logic [0:0]  out_mask;

  logic        start4 = 1'b0, ready4 = 1'b1;
  logic        out_valid4, out_eol4, out_eof4, busy4, done4;
  logic [9:0]  out_x4, out_y4;
  logic [127:0] out_re4;
  logic [31:0] out_im4;
  logic [3:0]  out_mask4;

  int n_cmp = 0;
  int n_bad = 0;
  beat_t tbl [6];
  beat_t sb [$];

  always #5 clk = ~clk;

  mandel_pixel_scanner #(.LANES(1), .XY_W(10), .COORD_W(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .x_size(x_size), .y_size(y_size), .re_min(re_min), .im_max(im_max), .delta(delta),
    .out_ready(ready), .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
    .out_re(out_re), .out_im(out_im), .out_mask(out_mask), .out_eol(out_eol),
    .out_eof(out_eof), .busy(busy), .done(done)
  );

  mandel_pixel_scanner #(.LANES(4), .XY_W(10), .COORD_W(32)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(1'b0),
    .x_size(x_size), .y_size(y_size), .re_min(re_min), .im_max(im_max), .delta(delta),
    .out_ready(ready4), .out_valid(out_valid4), .out_x(out_x4), .out_y(out_y4),
    .out_re(out_re4), .out_im(out_im4), .out_mask(out_mask4), .out_eol(out_eol4),
    .out_eof(out_eof4), .busy(busy4), .done(done4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: transfers pop the queue, stalls must hold every output
  logic [87:0] snap;
  bit          stalled = 1'b0;
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled && !abort) begin
        n_cmp++;
        if ({out_valid, out_x, out_y, out_re, out_im, out_mask, out_eol, out_eof} !== snap) begin
          n_bad++;
          $display("FAIL stall_hold: got %h expected %h",
                   {out_valid, out_x, out_y, out_re, out_im, out_mask, out_eol, out_eof}, snap);
        end
      end
      stalled = 1'b0;
      if (out_valid && !abort) begin
        if (ready) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_beat: x=%0d y=%0d with empty scoreboard", out_x, out_y);
          end else begin
            e = sb.pop_front();
            if (out_x !== e.x || out_y !== e.y || out_re !== e.re || out_im !== e.im ||
                out_eol !== e.eol || out_eof !== e.eof || out_mask !== 1'b1) begin
              n_bad++;
              $display("FAIL beat: got x=%0d y=%0d re=%h im=%h eol=%b eof=%b mask=%b expected x=%0d y=%0d re=%h im=%h eol=%b eof=%b mask=1",
                       out_x, out_y, out_re, out_im, out_eol, out_eof, out_mask,
                       e.x, e.y, e.re, e.im, e.eol, e.eof);
            end
          end
        end else begin
          stalled = 1'b1;
          snap = {out_valid, out_x, out_y, out_re, out_im, out_mask, out_eol, out_eof};
        end
      end
    end
  end

  task automatic run_frame(input bit rnd, input bit poke);
    int done_cyc;
    done_cyc = 0;
    for (int i = 0; i < 6; i++) sb.push_back(tbl[i]);
    @(posedge clk); #1;
    start = 1'b1;
    ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int cyc = 1; cyc <= 200 && done_cyc == 0; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (rnd) ready = 1'($urandom_range(0, 1));
      if (poke && cyc == 3) begin
        start  = 1'b1;
        x_size = 10'd7;
      end
      if (poke && cyc == 4) x_size = 10'd3;
      @(negedge clk);
      if (done) done_cyc = cyc;
    end
    ready = 1'b1;
    chk("done_seen", 64'(done_cyc != 0), 64'd1);
    if (!rnd) chk("done_latency", 64'(done_cyc), 64'd7);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{x: 10'd0, y: 10'd0, re: 32'hE000_0000, im: 32'h1000_0000, eol: 1'b0, eof: 1'b0};
    tbl[1] = '{x: 10'd1, y: 10'd0, re: 32'hE800_0000, im: 32'h1000_0000, eol: 1'b0, eof: 1'b0};
    tbl[2] = '{x: 10'd2, y: 10'd0, re: 32'hF000_0000, im: 32'h1000_0000, eol: 1'b1, eof: 1'b0};
    tbl[3] = '{x: 10'd0, y: 10'd1, re: 32'hE000_0000, im: 32'h0800_0000, eol: 1'b0, eof: 1'b0};
    tbl[4] = '{x: 10'd1, y: 10'd1, re: 32'hE800_0000, im: 32'h0800_0000, eol: 1'b0, eof: 1'b0};
    tbl[5] = '{x: 10'd2, y: 10'd1, re: 32'hF000_0000, im: 32'h0800_0000, eol: 1'b1, eof: 1'b1};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_xy",    64'({out_x, out_y}), 64'd0);
    chk("rst_re_im", {out_re, out_im}, 64'd0);
    chk("rst_flags", 64'({out_mask, out_eol, out_eof}), 64'd0);
    chk("rst_mask4", 64'({out_valid4, out_mask4}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic 3x2 frame, then with random backpressure
    run_frame(1'b0, 1'b0);
    run_frame(1'b1, 1'b0);

    // Abort while the third beat is presented
    sb.push_back(tbl[0]);
    sb.push_back(tbl[1]);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy",  64'(busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", 64'(done), 64'd0);
      @(negedge clk);
    end
    chk("abort_sb_empty", 64'(sb.size()), 64'd0);
    run_frame(1'b0, 1'b0);

    // Zero-width frame: no beats, done one cycle after start
    x_size = 10'd0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("zero_done",  64'(done), 64'd1);
    chk("zero_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("zero_done_end", 64'(done), 64'd0);
    x_size = 10'd3;

    // Start pulse and config change during SCAN are ignored
    run_frame(1'b0, 1'b1);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 6; i++) sb.push_back(tbl[i]);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("amid_valid_busy_done", 64'({out_valid, busy, done}), 64'd0);
    chk("amid_xy",    64'({out_x, out_y}), 64'd0);
    chk("amid_re_im", {out_re, out_im}, 64'd0);
    chk("amid_flags", 64'({out_mask, out_eol, out_eof}), 64'd0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("amid_no_done", 64'({done, out_valid}), 64'd0);
    end

    // Four-lane 6x1 frame
    x_size = 10'd6;
    y_size = 10'd1;
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    @(negedge clk);
    chk("l4_b1_ctl",  64'({out_valid4, busy4, out_x4, out_y4, out_mask4, out_eol4, out_eof4}),
                      64'({1'b1, 1'b1, 10'd0, 10'd0, 4'b1111, 1'b0, 1'b0}));
    chk("l4_b1_re01", out_re4[63:0],   64'hE800_0000_E000_0000);
    chk("l4_b1_re23", out_re4[127:64], 64'hF800_0000_F000_0000);
    chk("l4_b1_im",   64'(out_im4), 64'h1000_0000);
    @(negedge clk);
    chk("l4_b2_ctl",  64'({out_valid4, out_x4, out_mask4, out_eol4, out_eof4}),
                      64'({1'b1, 10'd4, 4'b0011, 1'b1, 1'b1}));
    chk("l4_b2_re01", out_re4[63:0], 64'h0800_0000_0000_0000);
    @(negedge clk);
    chk("l4_done", 64'({done4, out_valid4}), 64'b10);
    x_size = 10'd3;
    y_size = 10'd2;

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mandel_pixel_scanner.md
MANDEL_PIXEL_SCANNER -- requirements
Module: mandel_pixel_scanner

Interface
REQ-001 Parameter LANES, default 1, pixels per output beat; legal values 1, 2, 4.
REQ-002 Parameter XY_W, default 10, width of pixel coordinates and frame sizes.
REQ-003 Parameter COORD_W, default 32, width of signed fixed-point coordinates, format Q4.(COORD_W-4).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  frame request; sampled only in IDLE.
REQ-007 abort  in  1  cancel the current frame.
REQ-008 x_size, y_size  in  XY_W each  frame width and height in pixels.
REQ-009 re_min, im_max, delta  in  COORD_W each  left real edge, top imaginary edge, pixel pitch.
REQ-010 out_valid  out  1 / out_ready  in  1  beat handshake; transfer when both are high on a clock edge.
REQ-011 out_x, out_y  out  XY_W each  pixel position of lane 0.
REQ-012 out_re  out  LANES*COORD_W  real coordinate per lane; lane k in bits [k*COORD_W +: COORD_W].
REQ-013 out_im  out  COORD_W  imaginary coordinate, common to all lanes.
REQ-014 out_mask  out  LANES  per-lane valid mask / out_eol  out  1  last beat of a row / out_eof  out  1  last beat of the frame.
REQ-015 busy  out  1  high in SCAN / done  out  1  one-cycle pulse at frame completion.

Function
REQ-016 States IDLE, SCAN, DONE: IDLE->SCAN on start with both sizes non-zero; IDLE->DONE on start with either size zero; SCAN->DONE when the out_eof beat transfers; DONE->IDLE unconditionally after one cycle.
REQ-017 x_size, y_size, re_min, im_max and delta are latched on the start edge; input changes during SCAN have no effect.
REQ-018 out_valid is high in every SCAN cycle and low in all other states; the first beat is presented on the cycle after start is sampled.
REQ-019 While out_valid is high and out_ready is low, all out_* signals hold their values.
REQ-020 Lane k of a beat has x = out_x + k, out_re lane k = re_min + (out_x + k)*delta, and out_im = im_max - out_y*delta; all arithmetic is modulo 2^COORD_W, with no saturation.
REQ-021 Coordinates are generated incrementally by adding or subtracting delta; no multiplier is used.
REQ-022 out_mask bit k = 1 iff out_x + k < x_size; masked lanes carry don't-care out_re.
REQ-023 out_eol = 1 iff out_x + LANES >= x_size; out_eof = out_eol and out_y == y_size - 1.
REQ-024 A transfer without out_eol advances out_x by LANES; a transfer with out_eol sets out_x = 0, increments out_y, and moves out_im down by delta.
REQ-025 done pulses for exactly the DONE cycle and is also produced for a zero-size frame, which emits no beats.
REQ-026 start while busy or in DONE is ignored.
REQ-027 abort in SCAN forces IDLE on the next edge; no done pulse follows, and any beat presented in that cycle does not count as transferred; abort in IDLE or DONE has no effect.
REQ-028 Simultaneous abort and start in IDLE: start wins.

Reset
REQ-029 rst forces IDLE with out_valid = 0, busy = 0, done = 0, out_x = out_y = 0, out_re = out_im = 0, out_mask = 0, out_eol = out_eof = 0, and all latched configuration cleared to 0.
REQ-030 rst asserted mid-frame abandons the frame immediately and produces no done pulse.

Structure
REQ-031 Shared package mandel_pkg holds the state enum (IDLE, SCAN, DONE), the FRAC_BITS constant (COORD_W-4) and the coord_t typedef.
REQ-032 The block is a single module with no sub-modules; per-lane offsets k*delta are computed once at start and kept in registers.

Verification (Q4.28: 1.0 = 0x10000000)
REQ-033 LANES=1, frame 3x2, re_min=-2.0, im_max=1.0, delta=0.5, out_ready held high -> 6 beats: (0,0,-2.0,1.0) (1,0,-1.5,1.0) (2,0,-1.0,1.0,eol) (0,1,-2.0,0.5) (1,1,-1.5,0.5) (2,1,-1.0,0.5,eol,eof); done pulses on the following cycle.
REQ-034 LANES=4, frame 6x1 -> beat 1 has mask 1111 and re lanes -2.0/-1.5/-1.0/-0.5; beat 2 has out_x=4, mask 0011, eol=1, eof=1.
REQ-035 Frame 3x2 with out_ready toggling pseudo-randomly -> outputs stable while stalled, beat sequence identical to REQ-033, no beat dropped or duplicated.
REQ-036 abort asserted during the 3rd beat -> IDLE on the next cycle, out_valid=0, no done; a new start then reproduces the full REQ-033 sequence.
REQ-037 start with x_size=0 -> no beats, done pulses one cycle later; start pulsed during SCAN -> ignored, frame completes normally.
REQ-038 rst asserted mid-frame -> all outputs take REQ-029 values on the same cycle, with no clock edge required.
